// File: rtl/line_mem_responder.sv
// line_mem_responder: cache-line-wide memory target with fixed response latency.
// One request is handled at a time. Reads return the whole aligned line, and
// writes store byte/word/line data. A sticky drain flag blocks further traffic.
module line_mem_responder #(
    parameter int unsigned MEM_SIZE   = 16384,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 128,
    parameter int unsigned LATENCY    = 5
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    rd_req_valid_i,
    input  logic                    wr_req_valid_i,
    input  logic                    req_is_instr_i,
    input  logic [ADDR_WIDTH-1:0]   address_i,
    input  logic [DATA_WIDTH-1:0]   wr_data_i,
    input  logic [1:0]              access_size_i,
    input  logic                    finish_i,
    output logic                    data_valid_o,
    output logic                    data_is_instr_o,
    output logic [DATA_WIDTH-1:0]   data_o,
    output logic                    write_done_o,
    output logic                    done_o,
    output logic [8*MEM_SIZE-1:0]   debug_mem_o
);

    localparam int unsigned LB    = DATA_WIDTH / 8;
    localparam int unsigned IDX_W = $clog2(MEM_SIZE);
    localparam int unsigned LB_W  = $clog2(LB);
    localparam int unsigned CNT_W = (LATENCY > 3) ? $clog2(LATENCY - 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'((LATENCY >= 2) ? (LATENCY - 2) : 0);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RESP} state_t;

    state_t                 r_state;
    logic [CNT_W-1:0]       r_cnt;
    logic                   r_is_wr;
    logic                   r_is_instr;
    logic [1:0]             r_size;
    logic [IDX_W-1:0]       r_addr;
    logic [DATA_WIDTH-1:0]  r_wdata;
    logic                   r_data_valid;
    logic                   r_write_done;
    logic                   r_data_is_instr;
    logic [DATA_WIDTH-1:0]  r_data;
    logic                   r_done;
    logic [7:0]             r_mem [MEM_SIZE] = '{default: '0};

    logic                   w_accept;
    logic                   w_fire;
    logic                   w_op_wr;
    logic                   w_op_instr;
    logic [1:0]             w_op_size;
    logic [IDX_W-1:0]       w_op_addr;
    logic [DATA_WIDTH-1:0]  w_op_wdata;
    logic [IDX_W-1:0]       w_base;
    logic [IDX_W-1:0]       w_start;
    logic [31:0]            w_nbytes;
    logic [IDX_W-1:0]       w_idx [LB];
    logic [LB-1:0]          w_wen;
    logic                   w_unused;

    assign w_unused = ^address_i[ADDR_WIDTH-1:IDX_W];

    assign w_accept = (r_state == S_IDLE) && !r_done && !finish_i &&
                      (rd_req_valid_i || wr_req_valid_i);

    // With LATENCY == 1 the response is produced on the accepting edge itself,
    // so the operation fields come straight from the inputs while in IDLE.
    assign w_fire = ((r_state == S_IDLE) && w_accept && (LATENCY == 1)) ||
                    ((r_state == S_BUSY) && (r_cnt == '0));

    // Select the operation being served: live inputs in IDLE, latched copy otherwise
    always_comb begin
        if (r_state == S_IDLE) begin
            w_op_wr    = wr_req_valid_i;
            w_op_instr = req_is_instr_i;
            w_op_size  = access_size_i;
            w_op_addr  = address_i[IDX_W-1:0];
            w_op_wdata = wr_data_i;
        end else begin
            w_op_wr    = r_is_wr;
            w_op_instr = r_is_instr;
            w_op_size  = r_size;
            w_op_addr  = r_addr;
            w_op_wdata = r_wdata;
        end
    end

    // Per-byte storage indices (wrapping mod MEM_SIZE) and write enables
    always_comb begin
        w_base   = {w_op_addr[IDX_W-1:LB_W], {LB_W{1'b0}}};
        w_start  = (!w_op_wr || (w_op_size == 2'b11)) ? w_base : w_op_addr;
        w_nbytes = (w_op_size == 2'b11) ? 32'(LB) :
                   (w_op_size == 2'b10) ? 32'd4 : 32'd1;
        w_wen    = '0;
        for (int unsigned k = 0; k < LB; k++) begin
            w_idx[k] = w_start + IDX_W'(k);
            w_wen[k] = w_fire && w_op_wr && !rst_i && (32'(k) < w_nbytes);
        end
    end

    // Storage update; the write commits on the edge that raises write_done_o,
    // so the new bytes are visible during the completion pulse. No reset.
    always_ff @(posedge clk_i) begin
        for (int unsigned k = 0; k < LB; k++) begin
            if (w_wen[k]) begin
                r_mem[w_idx[k]] <= w_op_wdata[k*8 +: 8];
            end
        end
    end

    // Request FSM with registered response pulses, read line and drain flag
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state         <= S_IDLE;
            r_cnt           <= '0;
            r_is_wr         <= 1'b0;
            r_is_instr      <= 1'b0;
            r_size          <= '0;
            r_addr          <= '0;
            r_wdata         <= '0;
            r_data_valid    <= 1'b0;
            r_write_done    <= 1'b0;
            r_data_is_instr <= 1'b0;
            r_data          <= '0;
            r_done          <= 1'b0;
        end else begin
            r_data_valid <= 1'b0;
            r_write_done <= 1'b0;
            if (w_fire) begin
                r_data_valid <= !w_op_wr;
                r_write_done <= w_op_wr;
                if (!w_op_wr) begin
                    r_data_is_instr <= w_op_instr;
                    for (int unsigned k = 0; k < LB; k++) begin
                        r_data[k*8 +: 8] <= r_mem[w_idx[k]];
                    end
                end
            end
            case (r_state)
                S_IDLE: begin
                    if (finish_i) begin
                        r_done <= 1'b1;
                    end
                    if (w_accept) begin
                        r_is_wr    <= wr_req_valid_i;
                        r_is_instr <= req_is_instr_i;
                        r_size     <= access_size_i;
                        r_addr     <= address_i[IDX_W-1:0];
                        r_wdata    <= wr_data_i;
                        r_cnt      <= CNT_LOAD;
                        r_state    <= (LATENCY == 1) ? S_RESP : S_BUSY;
                    end
                end
                S_BUSY: begin
                    if (r_cnt == '0) begin
                        r_state <= S_RESP;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_RESP:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign data_valid_o    = r_data_valid;
    assign write_done_o    = r_write_done;
    assign data_is_instr_o = r_data_is_instr;
    assign data_o          = r_data;
    assign done_o          = r_done;

    for (genvar g = 0; g < MEM_SIZE; g++) begin : g_dbg
        assign debug_mem_o[8*g +: 8] = r_mem[g];
    end

endmodule

// File: tb/tb_line_mem_responder.sv
// Bench for line_mem_responder: directed scenarios plus randomized traffic
// checked against a byte-array reference model of the storage.
module tb_line_mem_responder;

    localparam int unsigned MEM_SIZE = 16384;
    localparam int unsigned AW       = 32;
    localparam int unsigned DW       = 128;
    localparam int unsigned LAT      = 5;
    localparam int unsigned LB       = DW / 8;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              rd_v = 1'b0;
    logic              wr_v = 1'b0;
    logic              instr = 1'b0;
    logic [AW-1:0]     addr = '0;
    logic [DW-1:0]     wdata = '0;
    logic [1:0]        size = '0;
    logic              finish = 1'b0;
    logic              data_valid;
    logic              data_is_instr;
    logic [DW-1:0]     data;
    logic              write_done;
    logic              done;
    logic [8*MEM_SIZE-1:0] dbg;

    logic [7:0] model [MEM_SIZE];
    int checks   = 0;
    int failures = 0;

    line_mem_responder #(
        .MEM_SIZE   (MEM_SIZE),
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .LATENCY    (LAT)
    ) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .rd_req_valid_i  (rd_v),
        .wr_req_valid_i  (wr_v),
        .req_is_instr_i  (instr),
        .address_i       (addr),
        .wr_data_i       (wdata),
        .access_size_i   (size),
        .finish_i        (finish),
        .data_valid_o    (data_valid),
        .data_is_instr_o (data_is_instr),
        .data_o          (data),
        .write_done_o    (write_done),
        .done_o          (done),
        .debug_mem_o     (dbg)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] dbyte(input int unsigned i);
        return dbg[8*i +: 8];
    endfunction

    function automatic int unsigned nbytes_of(input logic [1:0] s);
        if (s == 2'b11) return LB;
        if (s == 2'b10) return 4;
        return 1;
    endfunction

    function automatic int unsigned start_of(input logic [AW-1:0] a, input logic [1:0] s);
        int unsigned m = a % MEM_SIZE;
        return (s == 2'b11) ? (m & ~(LB - 1)) : m;
    endfunction

    function automatic logic [DW-1:0] exp_line(input logic [AW-1:0] a);
        logic [DW-1:0] l;
        int unsigned base = (a % MEM_SIZE) & ~(LB - 1);
        for (int k = 0; k < LB; k++) l[8*k +: 8] = model[base + k];
        return l;
    endfunction

    task automatic model_write(input logic [AW-1:0] a, input logic [1:0] s, input logic [DW-1:0] d);
        int unsigned st = start_of(a, s);
        for (int k = 0; k < nbytes_of(s); k++) model[(st + k) % MEM_SIZE] = d[8*k +: 8];
    endtask

    // Compare the written region plus one neighbouring byte each side
    task automatic chk_region(input string tag, input logic [AW-1:0] a, input logic [1:0] s);
        int unsigned st = start_of(a, s);
        for (int k = -1; k <= int'(nbytes_of(s)); k++) begin
            int unsigned i = (st + MEM_SIZE + k) % MEM_SIZE;
            chk($sformatf("%s_byte%0h", tag, i), dbyte(i), model[i]);
        end
    endtask

    // Present a request for exactly one edge (the acceptance edge)
    task automatic send(input logic r, input logic w, input logic ins, input logic [AW-1:0] a,
                        input logic [1:0] s, input logic [DW-1:0] d);
        @(posedge clk); #1;
        rd_v = r; wr_v = w; instr = ins; addr = a; size = s; wdata = d;
        @(posedge clk); #1;
        rd_v = 1'b0; wr_v = 1'b0;
    endtask

    // Count edges after acceptance until a response pulse, bounded
    task automatic wait_resp(output int lat);
        lat = -1;
        for (int n = 1; n <= 20 && lat < 0; n++) begin
            @(posedge clk); #1;
            if (data_valid || write_done) lat = n;
        end
    endtask

    // Full transaction with response, latency, storage and pulse-width checks
    task automatic xact(input string tag, input logic r, input logic w, input logic ins,
                        input logic [AW-1:0] a, input logic [1:0] s, input logic [DW-1:0] d);
        int lat;
        send(r, w, ins, a, s, d);
        wait_resp(lat);
        chk({tag, "_lat"}, lat, LAT - 1);
        if (w) begin
            model_write(a, s, d);
            chk({tag, "_wdone"}, write_done, 1'b1);
            chk({tag, "_novalid"}, data_valid, 1'b0);
            chk_region(tag, a, s);
        end else begin
            chk({tag, "_valid"}, data_valid, 1'b1);
            chk({tag, "_data"}, data, exp_line(a));
            chk({tag, "_instr"}, data_is_instr, ins);
        end
        @(posedge clk); #1;
        chk({tag, "_pulse_end"}, {data_valid, write_done}, 2'b00);
    endtask

    initial begin
        int nrd, nwr, lat, mism;
        logic done_at_resp;
        logic [AW-1:0] ra;
        logic [1:0] rs;
        logic [DW-1:0] rd_data;

        for (int i = 0; i < MEM_SIZE; i++) model[i] = 8'h00;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", data_valid, 1'b0);
        chk("rst_wdone", write_done, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_instr", data_is_instr, 1'b0);
        chk("rst_data", data, '0);
        chk("rst_mem_zero", dbyte(32'h1000), 8'h00);
        rst = 1'b0;

        // Preload 0x1000..0x100F with 00..0F, then line read of 0x1004
        xact("preload", 1'b0, 1'b1, 1'b0, 32'h1000, 2'b11, 128'h0F0E0D0C0B0A09080706050403020100);
        xact("rd1004", 1'b1, 1'b0, 1'b1, 32'h1004, 2'b11, '0);
        chk("rd1004_const", data, 128'h0F0E0D0C0B0A09080706050403020100);

        // Word write crossing nothing, then line read of its line
        xact("sw2002", 1'b0, 1'b1, 1'b0, 32'h2002, 2'b10, 128'hDEADBEEF);
        chk("sw2002_bytes", {dbyte(32'h2005), dbyte(32'h2004), dbyte(32'h2003), dbyte(32'h2002)}, 32'hDEADBEEF);
        xact("rd2000", 1'b1, 1'b0, 1'b0, 32'h2000, 2'b00, '0);
        chk("rd2000_const", data, 128'h0000000000000000000000DEADBEEF0000);

        // Byte at top of memory, then wrapping word write
        xact("sb_top", 1'b0, 1'b1, 1'b0, MEM_SIZE - 1, 2'b00, 128'hAA);
        chk("sb_top_byte", dbyte(MEM_SIZE - 1), 8'hAA);
        xact("sw_wrap", 1'b0, 1'b1, 1'b0, MEM_SIZE - 2, 2'b10, 128'h11223344);
        chk("sw_wrap_bytes", {dbyte(1), dbyte(0), dbyte(MEM_SIZE - 1), dbyte(MEM_SIZE - 2)}, 32'h11223344);

        // Randomized traffic; addresses carry random upper bits and cluster low or at the top
        for (int t = 0; t < 60; t++) begin
            logic [AW-1:0] lo;
            lo = ($urandom_range(0, 3) == 0) ? AW'(MEM_SIZE - $urandom_range(1, 20)) : AW'($urandom_range(0, 255));
            ra = ($urandom & ~(MEM_SIZE - 1)) | lo;
            rs = 2'($urandom_range(0, 3));
            rd_data = {$urandom, $urandom, $urandom, $urandom};
            if ($urandom_range(0, 1) == 1)
                xact($sformatf("rnd%0d_wr", t), 1'b0, 1'b1, 1'($urandom_range(0, 1)), ra, rs, rd_data);
            else
                xact($sformatf("rnd%0d_rd", t), 1'b1, 1'b0, 1'($urandom_range(0, 1)), ra, rs, '0);
        end

        // Write presented during BUSY of a read is ignored
        send(1'b1, 1'b0, 1'b0, 32'h0040, 2'b11, '0);
        nrd = 0; nwr = 0;
        for (int n = 1; n <= LAT + 4; n++) begin
            @(posedge clk); #1;
            nrd += int'(data_valid);
            nwr += int'(write_done);
            if (n == 1) begin
                wr_v = 1'b1; addr = 32'h0300; size = 2'b11; wdata = {4{32'hCAFEF00D}};
            end
            if (n == 2) wr_v = 1'b0;
        end
        chk("busy_ign_rd", nrd, 1);
        chk("busy_ign_wr", nwr, 0);
        chk_region("busy_ign_mem", 32'h0300, 2'b11);

        // Simultaneous read and write: write wins
        send(1'b1, 1'b1, 1'b0, 32'h0310, 2'b10, 128'h55667788);
        nrd = 0; nwr = 0;
        for (int n = 1; n <= LAT + 4; n++) begin
            @(posedge clk); #1;
            nrd += int'(data_valid);
            nwr += int'(write_done);
        end
        model_write(32'h0310, 2'b10, 128'h55667788);
        chk("both_rd", nrd, 0);
        chk("both_wr", nwr, 1);
        chk_region("both_mem", 32'h0310, 2'b10);

        // Whole-array comparison against the model
        mism = 0;
        for (int i = 0; i < MEM_SIZE; i++) if (dbyte(i) !== model[i]) mism++;
        chk("mem_full", mism, 0);

        // Drain raised during BUSY: response still happens, then done sticks
        send(1'b0, 1'b1, 1'b0, 32'h0400, 2'b00, 128'h5A);
        lat = -1; done_at_resp = 1'b1;
        for (int n = 1; n <= LAT + 4; n++) begin
            @(posedge clk); #1;
            if (write_done) begin lat = n; done_at_resp = done; end
            if (n == 2) finish = 1'b1;
        end
        model_write(32'h0400, 2'b00, 128'h5A);
        chk("drain_lat", lat, LAT - 1);
        chk("drain_done_at_resp", done_at_resp, 1'b0);
        chk("drain_done", done, 1'b1);
        chk("drain_mem", dbyte(32'h0400), 8'h5A);
        send(1'b1, 1'b0, 1'b0, 32'h0400, 2'b11, '0);
        finish = 1'b0;
        send(1'b0, 1'b1, 1'b0, 32'h0410, 2'b11, {4{32'h01234567}});
        nrd = 0; nwr = 0;
        for (int n = 1; n <= LAT + 4; n++) begin
            @(posedge clk); #1;
            nrd += int'(data_valid);
            nwr += int'(write_done);
        end
        chk("drained_no_rd", nrd, 0);
        chk("drained_no_wr", nwr, 0);
        chk("drained_done_sticky", done, 1'b1);
        chk_region("drained_mem", 32'h0410, 2'b11);

        // Reset clears done
        @(posedge clk); #1; rst = 1'b1;
        @(posedge clk); #1; rst = 1'b0;
        chk("rst2_done", done, 1'b0);

        // Reset during BUSY of a write discards it
        send(1'b0, 1'b1, 1'b1, 32'h0500, 2'b11, {4{32'h89ABCDEF}});
        nwr = 0; nrd = 0;
        for (int n = 1; n <= LAT + 4; n++) begin
            @(posedge clk); #1;
            if (n == 3) begin
                chk("rstbusy_outs", {data_valid, write_done, done, data_is_instr}, 4'b0000);
                chk("rstbusy_data", data, '0);
                rst = 1'b0;
            end
            nwr += int'(write_done);
            nrd += int'(data_valid);
            if (n == 2) rst = 1'b1;
        end
        chk("rstbusy_no_wr", nwr, 0);
        chk("rstbusy_no_rd", nrd, 0);
        chk_region("rstbusy_mem", 32'h0500, 2'b11);

        // Still operational after reset
        xact("post_rst_rd", 1'b1, 1'b0, 1'b1, 32'h1008, 2'b11, '0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
